// File: rtl/cordic_quadrant_map_pipe.sv
// CORDIC pre-rotation: folds a vector/angle into -90..+90 deg with an exact +/-90 deg swap/negate.
// Optional raw input register, then correction logic feeding the output register; valid/ready on both sides.
module cordic_quadrant_map_pipe #(
   parameter int WIDTH   = 32,
   parameter int ANGLE_W = 32,
   parameter int TAG_W   = 4,
   parameter int REG_IN  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x_in,
   input  logic [WIDTH-1:0]   y_in,
   input  logic [ANGLE_W-1:0] angle_in,
   input  logic [TAG_W-1:0]   tag_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   x_out,
   output logic [WIDTH-1:0]   y_out,
   output logic [ANGLE_W-1:0] angle_out,
   output logic [1:0]         quad_out,
   output logic               sat_out,
   output logic               err_out,
   output logic [TAG_W-1:0]   tag_out
);

   localparam logic [WIDTH-1:0]   MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]   MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [ANGLE_W-1:0] Q90   = {3'b001, {(ANGLE_W-3){1'b0}}};
   localparam logic [1:0]         QUAD_NONE = 2'b00;
   localparam logic [1:0]         QUAD_M90  = 2'b01;
   localparam logic [1:0]         QUAD_P90  = 2'b10;

   // MSB of the result is the saturation flag
   function automatic logic [WIDTH:0] neg_sat(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] n;
      n = '0 - v;
      return (v == MIN_V) ? {1'b1, MAX_V} : {1'b0, n};
   endfunction

   logic               r_valid;
   logic               r_mode;
   logic [WIDTH-1:0]   r_x;
   logic [WIDTH-1:0]   r_y;
   logic [ANGLE_W-1:0] r_angle;
   logic [TAG_W-1:0]   r_tag;

   logic               out_valid_q;
   logic [WIDTH-1:0]   x_q, y_q;
   logic [ANGLE_W-1:0] angle_q;
   logic [1:0]         quad_q;
   logic               sat_q, err_q;
   logic [TAG_W-1:0]   tag_q;

   logic               out_take;
   assign out_take = !out_valid_q || out_ready;

   generate
      if (REG_IN != 0) begin : g_in_reg
         logic               s0_valid_q;
         logic               s0_mode_q;
         logic [WIDTH-1:0]   s0_x_q, s0_y_q;
         logic [ANGLE_W-1:0] s0_angle_q;
         logic [TAG_W-1:0]   s0_tag_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s0_valid_q <= 1'b0;
               s0_mode_q  <= 1'b0;
               s0_x_q     <= '0;
               s0_y_q     <= '0;
               s0_angle_q <= '0;
               s0_tag_q   <= '0;
            end else if (in_ready) begin
               s0_valid_q <= in_valid;
               if (in_valid) begin
                  s0_mode_q  <= mode;
                  s0_x_q     <= x_in;
                  s0_y_q     <= y_in;
                  s0_angle_q <= angle_in;
                  s0_tag_q   <= tag_in;
               end
            end
         end

         assign in_ready = !s0_valid_q || out_take;
         assign r_valid  = s0_valid_q;
         assign r_mode   = s0_mode_q;
         assign r_x      = s0_x_q;
         assign r_y      = s0_y_q;
         assign r_angle  = s0_angle_q;
         assign r_tag    = s0_tag_q;
      end else begin : g_no_reg
         assign in_ready = out_take;
         assign r_valid  = in_valid;
         assign r_mode   = mode;
         assign r_x      = x_in;
         assign r_y      = y_in;
         assign r_angle  = angle_in;
         assign r_tag    = tag_in;
      end
   endgenerate

   logic [WIDTH:0]     neg_x, neg_y;
   logic [WIDTH-1:0]   x_d, y_d;
   logic [ANGLE_W-1:0] angle_d;
   logic [1:0]         quad_d;
   logic               sat_d, err_d;
   logic [1:0]         rot_q;

   assign neg_x = neg_sat(r_x);
   assign neg_y = neg_sat(r_y);
   assign rot_q = r_angle[ANGLE_W-2:ANGLE_W-3];

   always_comb begin
      x_d     = r_x;
      y_d     = r_y;
      angle_d = r_angle;
      quad_d  = QUAD_NONE;
      sat_d   = 1'b0;
      err_d   = 1'b0;
      if (!r_mode) begin
         if (r_angle[ANGLE_W-1] != r_angle[ANGLE_W-2]) begin
            err_d = 1'b1;
         end else if (rot_q == 2'b01) begin
            x_d     = neg_y[WIDTH-1:0];
            y_d     = r_x;
            angle_d = r_angle - Q90;
            quad_d  = QUAD_M90;
            sat_d   = neg_y[WIDTH];
         end else if (rot_q == 2'b10) begin
            x_d     = r_y;
            y_d     = neg_x[WIDTH-1:0];
            angle_d = r_angle + Q90;
            quad_d  = QUAD_P90;
            sat_d   = neg_x[WIDTH];
         end
      end else if (r_x[WIDTH-1]) begin
         // Vector in left half-plane: rotate toward +x using the sign of y
         if (!r_y[WIDTH-1]) begin
            x_d     = r_y;
            y_d     = neg_x[WIDTH-1:0];
            angle_d = r_angle + Q90;
            quad_d  = QUAD_P90;
            sat_d   = neg_x[WIDTH];
         end else begin
            x_d     = neg_y[WIDTH-1:0];
            y_d     = r_x;
            angle_d = r_angle - Q90;
            quad_d  = QUAD_M90;
            sat_d   = neg_y[WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         angle_q     <= '0;
         quad_q      <= QUAD_NONE;
         sat_q       <= 1'b0;
         err_q       <= 1'b0;
         tag_q       <= '0;
      end else if (out_take) begin
         out_valid_q <= r_valid;
         if (r_valid) begin
            x_q     <= x_d;
            y_q     <= y_d;
            angle_q <= angle_d;
            quad_q  <= quad_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
            tag_q   <= r_tag;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign angle_out = angle_q;
   assign quad_out  = quad_q;
   assign sat_out   = sat_q;
   assign err_out   = err_q;
   assign tag_out   = tag_q;

endmodule

// File: tb/tb_cordic_quadrant_map_pipe.sv
// Directed bench: u0 (REG_IN=0) for correction vectors, u1 (REG_IN=1) for backpressure and reset.
module tb_cordic_quadrant_map_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] x_in = '0, y_in = '0, angle_in = '0;
   logic [3:0]  tag_in = '0;

   logic        in_valid0 = 1'b0, out_ready0 = 1'b1, in_ready0, out_valid0;
   logic [31:0] x_out0, y_out0, angle_out0;
   logic [1:0]  quad_out0;
   logic        sat_out0, err_out0;
   logic [3:0]  tag_out0;

   logic        in_valid1 = 1'b0, out_ready1 = 1'b1, in_ready1, out_valid1;
   logic [31:0] x_out1, y_out1, angle_out1;
   logic [1:0]  quad_out1;
   logic        sat_out1, err_out1;
   logic [3:0]  tag_out1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cordic_quadrant_map_pipe #(.WIDTH(32), .ANGLE_W(32), .TAG_W(4), .REG_IN(0)) u0 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid0), .in_ready(in_ready0),
      .x_in(x_in), .y_in(y_in), .angle_in(angle_in), .tag_in(tag_in),
      .out_valid(out_valid0), .out_ready(out_ready0), .x_out(x_out0), .y_out(y_out0),
      .angle_out(angle_out0), .quad_out(quad_out0), .sat_out(sat_out0), .err_out(err_out0),
      .tag_out(tag_out0));

   cordic_quadrant_map_pipe #(.WIDTH(32), .ANGLE_W(32), .TAG_W(4), .REG_IN(1)) u1 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid1), .in_ready(in_ready1),
      .x_in(x_in), .y_in(y_in), .angle_in(angle_in), .tag_in(tag_in),
      .out_valid(out_valid1), .out_ready(out_ready1), .x_out(x_out1), .y_out(y_out1),
      .angle_out(angle_out1), .quad_out(quad_out1), .sat_out(sat_out1), .err_out(err_out1),
      .tag_out(tag_out1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One sample through u0; output must be valid exactly one cycle later
   task automatic run_vec(input string name, input logic m, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] a, input logic [3:0] t,
                          input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ea,
                          input logic [1:0] eq, input logic es, input logic ee);
      @(negedge clk);
      mode = m; x_in = x; y_in = y; angle_in = a; tag_in = t; in_valid0 = 1'b1;
      @(negedge clk);
      in_valid0 = 1'b0;
      #1;
      chk({name, ".valid"}, out_valid0, 1);
      chk({name, ".x"}, x_out0, ex);
      chk({name, ".y"}, y_out0, ey);
      chk({name, ".angle"}, angle_out0, ea);
      chk({name, ".quad"}, quad_out0, eq);
      chk({name, ".sat"}, sat_out0, es);
      chk({name, ".err"}, err_out0, ee);
      chk({name, ".tag"}, tag_out0, t);
   endtask

   int   sent, rcv, cnt;
   logic stall_prev, acc_in, acc_out;
   logic [31:0] held_x;
   logic [3:0]  held_tag;

   initial begin
      #1;
      chk("rst.v0", out_valid0, 0);
      chk("rst.v1", out_valid1, 0);
      chk("rst.x0", x_out0, 0);
      chk("rst.a1", angle_out1, 0);
      chk("rst.q0", {quad_out0, sat_out0, err_out0, tag_out0}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      //       name      m  x             y             angle         tag  exp x         exp y         exp angle     q  s  e
      run_vec("rot01",  0, 32'h4000,     32'h1000,     32'h3000_0000, 1, 32'hFFFF_F000, 32'h4000,     32'h1000_0000, 1, 0, 0);
      run_vec("rot10",  0, 32'h4000,     32'h1000,     32'hD000_0000, 2, 32'h1000,     32'hFFFF_C000, 32'hF000_0000, 2, 0, 0);
      run_vec("err",    0, 32'h4000,     32'h1000,     32'h5000_0000, 3, 32'h4000,     32'h1000,     32'h5000_0000, 0, 0, 1);
      run_vec("sat",    0, 32'h5,        32'h8000_0000, 32'h3000_0000, 4, 32'h7FFF_FFFF, 32'h5,       32'h1000_0000, 1, 1, 0);
      run_vec("vec10",  1, 32'hFFFF_F000, 32'h100,     32'h0,         5, 32'h100,      32'h1000,     32'h2000_0000, 2, 0, 0);
      run_vec("vec01",  1, 32'hFFFF_F000, 32'hFFFF_FF00, 32'h1000,    6, 32'h100,      32'hFFFF_F000, 32'hE000_1000, 1, 0, 0);
      run_vec("vecpass",1, 32'h0,        32'hFFFF_FFFB, 32'h7,        7, 32'h0,        32'hFFFF_FFFB, 32'h7,        0, 0, 0);
      run_vec("vecsat", 1, 32'h8000_0000, 32'h0,       32'h0,         8, 32'h0,        32'h7FFF_FFFF, 32'h2000_0000, 2, 1, 0);
      run_vec("vecnoerr",1, 32'h1,       32'h1,        32'h5000_0000, 9, 32'h1,        32'h1,        32'h5000_0000, 0, 0, 0);
      run_vec("p90",    0, 32'h3,        32'h4,        32'h2000_0000, 10, 32'hFFFF_FFFC, 32'h3,       32'h0,         1, 0, 0);
      run_vec("m90",    0, 32'h3,        32'h4,        32'hE000_0000, 11, 32'h3,        32'h4,        32'hE000_0000, 0, 0, 0);
      run_vec("m180",   0, 32'h7,        32'h9,        32'hC000_0000, 12, 32'h9,        32'hFFFF_FFF9, 32'hE000_0000, 2, 0, 0);
      @(negedge clk);
      #1;
      chk("u0.idle", out_valid0, 0);

      // Backpressure on u1 with random out_ready
      sent = 0; rcv = 0; cnt = 0; stall_prev = 1'b0;
      for (int cyc = 0; cyc < 300 && rcv < 8; cyc++) begin
         @(negedge clk);
         out_ready1 = (cyc >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
         in_valid1  = (sent < 8);
         mode = 1'b0; angle_in = 32'h0; y_in = 32'h0;
         x_in = 32'(100 + sent); tag_in = 4'(sent);
         #1;
         if (stall_prev) begin
            chk("bp.hold_v", out_valid1, 1);
            chk("bp.hold_x", x_out1, held_x);
            chk("bp.hold_tag", tag_out1, held_tag);
         end
         chk("bp.in_ready", in_ready1, !(cnt == 2 && !out_ready1));
         acc_in  = in_valid1 && in_ready1;
         acc_out = out_valid1 && out_ready1;
         if (acc_out) begin
            chk("bp.tag", tag_out1, 4'(rcv));
            chk("bp.x", x_out1, 32'(100 + rcv));
            rcv++;
         end
         stall_prev = out_valid1 && !out_ready1;
         held_x = x_out1;
         held_tag = tag_out1;
         if (acc_in) sent++;
         cnt = cnt + int'(acc_in) - int'(acc_out);
      end
      chk("bp.count", 32'(rcv), 8);
      @(negedge clk);
      in_valid1 = 1'b0; out_ready1 = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("bp.no_dup", out_valid1, 0);

      // Reset with two samples in flight on u1
      @(negedge clk);
      out_ready1 = 1'b0; in_valid1 = 1'b1; x_in = 32'h11; tag_in = 4'hA;
      @(negedge clk);
      x_in = 32'h22; tag_in = 4'hB;
      @(negedge clk);
      in_valid1 = 1'b0;
      #1;
      chk("mid.v_before", out_valid1, 1);
      chk("mid.tag_before", tag_out1, 4'hA);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid.v", out_valid1, 0);
      chk("mid.x", x_out1, 0);
      chk("mid.tag", tag_out1, 0);
      chk("mid.flags", {angle_out1, quad_out1, sat_out1, err_out1}, 0);
      @(negedge clk);
      rst_n = 1'b1; out_ready1 = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("post.idle", out_valid1, 0);
      @(negedge clk);
      in_valid1 = 1'b1; x_in = 32'h55; tag_in = 4'hC;
      @(negedge clk);
      in_valid1 = 1'b0;
      #1;
      chk("post.lat1", out_valid1, 0);
      @(negedge clk);
      #1;
      chk("post.lat2", out_valid1, 1);
      chk("post.tag", tag_out1, 4'hC);
      chk("post.x", x_out1, 32'h55);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cordic_quadrant_map_pipe.md
Name: cordic_quadrant_map_pipe

Overview:
- Pipelined, parametrised pre-rotation stage at the front of the CORDIC core.
- Folds an input vector/angle into the CORDIC convergence range (-90°..+90°) by an exact ±90° swap/negate.
- Supports rotation mode (decision from the angle) and vectoring mode (decision from the signs of x and y).
- Emits the quadrant code, saturation and range-error flags, and a pass-through tag so downstream stages can undo the correction.
- Uses valid/ready handshakes on both sides, with full backpressure support.

Parameters:
- WIDTH, 32, two's-complement width of x and y.
- ANGLE_W, 32, two's-complement angle width.
  - Angle scale: 90° = 2^(ANGLE_W-3).
  - Legal range: [-180°, +180°), i.e. angle[ANGLE_W-1] == angle[ANGLE_W-2].
- TAG_W, 4, width of the user tag carried alongside each sample.
- REG_IN, 0, 1 adds an input register stage. Latency = 1 + REG_IN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = rotation, 1 = vectoring; sampled with each accepted input.
- in_valid  in  1  input sample valid.
- in_ready  out  1  stage can accept a sample.
- x_in  in  WIDTH  signed x.
- y_in  in  WIDTH  signed y.
- angle_in  in  ANGLE_W  signed angle (rotation) or angle accumulator seed (vectoring).
- tag_in  in  TAG_W  user tag.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- x_out  out  WIDTH  corrected x.
- y_out  out  WIDTH  corrected y.
- angle_out  out  ANGLE_W  corrected angle.
- quad_out  out  2  correction applied: 00 none, 01 -90° applied to angle, 10 +90° applied to angle.
- sat_out  out  1  a negation saturated.
- err_out  out  1  rotation-mode angle outside the legal range.
- tag_out  out  TAG_W  tag of this sample.

Behaviour:
- Reset (async assert, sync release): all valid bits 0, and all data/flag registers 0.
  - Hence out_valid = 0, x_out = y_out = angle_out = 0, quad_out = 00, sat_out = err_out = 0, tag_out = 0.
- Handshake:
  - Transfer occurs on any cycle with valid && ready.
  - Each pipeline stage loads when it is empty or its content is being taken downstream.
  - in_ready = !stage_valid[0] || ready of the following stage. This is combinational from out_ready; no bubble under continuous flow.
  - out_valid, once high, holds and data stays stable until out_ready.
- Full throughput: one sample per cycle.
- Order is preserved; tag_out equals the tag_in of the same sample.
- Rotation mode: q = angle[ANGLE_W-2:ANGLE_W-3].
  - q = 00 or 11: pass through; quad_out = 00.
  - q = 01 (90°..180°): x' = -y, y' = x, angle' = angle - 2^(ANGLE_W-3); quad_out = 01.
  - q = 10 (-180°..-90°): x' = y, y' = -x, angle' = angle + 2^(ANGLE_W-3); quad_out = 10.
  - If angle[ANGLE_W-1] != angle[ANGLE_W-2]: err_out = 1 and data passes through unchanged with quad_out = 00.
- Vectoring mode (err_out always 0):
  - x >= 0: pass through; quad_out = 00.
  - x < 0, y >= 0: x' = y, y' = -x, angle' = angle + 90°; quad_out = 10.
  - x < 0, y < 0: x' = -y, y' = x, angle' = angle - 90°; quad_out = 01.
- Arithmetic rules:
  - Negation of -2^(WIDTH-1) saturates to 2^(WIDTH-1)-1 and sets sat_out. Otherwise sat_out = 0.
  - Angle add/subtract wraps modulo 2^ANGLE_W. It cannot overflow for legal inputs.
- Boundaries:
  - Exactly +90° (q = 01) is corrected to 0°.
  - Exactly -90° (0xE000_0000 at 32 bits, q = 11) passes through.
  - -180° (q = 10) is corrected to -90°.
- Logic placement: the correction logic sits combinationally before the final register. With REG_IN = 1, the input register holds raw values only.
- Reset mid-operation clears all in-flight samples; nothing is emitted afterward until new inputs arrive.

Test Plan:
- Rotation, q = 01. x = 0x4000, y = 0x1000, angle = 0x3000_0000 -> x_out = 0xFFFF_F000, y_out = 0x4000, angle_out = 0x1000_0000, quad_out = 01, latency 1 (REG_IN = 0).
- Rotation, q = 10. x = 0x4000, y = 0x1000, angle = 0xD000_0000 -> x_out = 0x1000, y_out = 0xFFFF_C000, angle_out = 0xF000_0000, quad_out = 10.
- Range error and saturation:
  - angle = 0x5000_0000 -> err_out = 1, outputs equal inputs, quad_out = 00.
  - Rotation q = 01 with y = 0x8000_0000 -> x_out = 0x7FFF_FFFF, sat_out = 1.
- Vectoring. x = 0xFFFF_F000 (-4096), y = 0x100, angle = 0 -> x_out = 0x100, y_out = 0x1000, angle_out = 0x2000_0000, quad_out = 10.
- Backpressure, REG_IN = 1. Stream tags 0..7 back-to-back while toggling out_ready randomly -> all 8 tags emerge in order, none lost or duplicated, data stable while out_valid && !out_ready, and in_ready low only when both stages are full and out_ready = 0.
- Reset mid-stream. Assert rst_n low with 2 samples in flight -> out_valid drops asynchronously and all outputs go to 0; after release, the first new sample appears after 1 + REG_IN cycles.
